// File: rtl/ctrl_result_drain.sv
// Drains per-row partial-sum words from the array into the result SRAM,
// reversing column order and buffering through a small FIFO.
module ctrl_result_drain #(
    parameter int NUM_COL    = 16,
    parameter int PSUM_BW    = 20,
    parameter int WORDSIZE   = NUM_COL * PSUM_BW,
    parameter int ADDR_W     = 8,
    parameter int ROW_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ROW_W-1:0]    num_rows,
    input  logic                psum_valid,
    input  logic [WORDSIZE-1:0] psum_data,
    output logic                psum_ready,
    output logic                mem_wr_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORDSIZE-1:0] mem_wdata,
    input  logic                mem_ready,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH,
        DONE
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   base_q;
    logic [ROW_W:0]      rows_q;
    logic [ROW_W:0]      acc_cnt;
    logic [ROW_W:0]      wr_cnt;
    logic                err_q;

    logic [WORDSIZE-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]      wptr, rptr;
    logic                fifo_full, fifo_empty;
    logic                push, pop, start_ok;
    logic [WORDSIZE-1:0] rev_word;

    // Column reversal is pure wiring in front of the FIFO.
    for (genvar j = 0; j < NUM_COL; j++) begin : g_rev
        assign rev_word[j*PSUM_BW +: PSUM_BW] = psum_data[(NUM_COL-1-j)*PSUM_BW +: PSUM_BW];
    end

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                        (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);

    assign start_ok   = (state == IDLE) && start;
    assign psum_ready = (state == DRAIN) && !fifo_full && (acc_cnt < rows_q);
    assign mem_wr_en  = ((state == DRAIN) || (state == FLUSH)) && !fifo_empty;
    assign push       = psum_valid && psum_ready;
    assign pop        = mem_wr_en && mem_ready;

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = err_q;
    assign mem_addr  = base_q + ADDR_W'(wr_cnt);
    // Head is gated so the unreset storage never leaks onto the bus when idle.
    assign mem_wdata = mem_wr_en ? fifo_mem[rptr[PTR_W-1:0]] : '0;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (num_rows == '0) ? DONE : DRAIN;
            DRAIN: if (push && (acc_cnt + 1'b1 == rows_q)) state_nxt = FLUSH;
            FLUSH: if (fifo_empty && (wr_cnt == rows_q)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            base_q  <= '0;
            rows_q  <= '0;
            acc_cnt <= '0;
            wr_cnt  <= '0;
            err_q   <= 1'b0;
            wptr    <= '0;
            rptr    <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                base_q  <= base_addr;
                rows_q  <= {1'b0, num_rows};
                acc_cnt <= '0;
                wr_cnt  <= '0;
                err_q   <= 1'b0;
            end else begin
                if (push) acc_cnt <= acc_cnt + 1'b1;
                if (pop)  wr_cnt  <= wr_cnt + 1'b1;
                if ((state == DRAIN) && psum_valid && fifo_full) err_q <= 1'b1;
            end
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the pointers alone define
    // validity, and the output gate keeps stale entries invisible.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr[PTR_W-1:0]] <= rev_word;
    end

endmodule

// File: tb/tb_ctrl_result_drain.sv
// Randomized self-checking bench for ctrl_result_drain against a queue-based
// model of accepted words and their expected SRAM writes.
module tb_ctrl_result_drain;

    localparam int NUM_COL  = 16;
    localparam int PSUM_BW  = 20;
    localparam int WORDSIZE = NUM_COL * PSUM_BW;
    localparam int ADDR_W   = 8;
    localparam int ROW_W    = 8;
    localparam int DEPTH    = 4;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [ROW_W-1:0]    num_rows;
    logic                psum_valid;
    logic [WORDSIZE-1:0] psum_data;
    logic                psum_ready;
    logic                mem_wr_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORDSIZE-1:0] mem_wdata;
    logic                mem_ready;
    logic                busy;
    logic                done;
    logic                err;

    int n_checks = 0;
    int n_errors = 0;

    ctrl_result_drain #(
        .NUM_COL(NUM_COL), .PSUM_BW(PSUM_BW), .WORDSIZE(WORDSIZE),
        .ADDR_W(ADDR_W), .ROW_W(ROW_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .psum_valid(psum_valid), .psum_data(psum_data),
        .psum_ready(psum_ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WORDSIZE-1:0] got,
                         input logic [WORDSIZE-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model view of a word: an array of columns, emitted in reverse order.
    function automatic logic [WORDSIZE-1:0] reverse_cols(input logic [WORDSIZE-1:0] w);
        logic [PSUM_BW-1:0]  cols [NUM_COL];
        logic [WORDSIZE-1:0] r;
        for (int c = 0; c < NUM_COL; c++) cols[c] = w[c*PSUM_BW +: PSUM_BW];
        r = '0;
        for (int c = 0; c < NUM_COL; c++) r[c*PSUM_BW +: PSUM_BW] = cols[NUM_COL-1-c];
        return r;
    endfunction

    function automatic logic [WORDSIZE-1:0] pattern_word(input int row);
        logic [WORDSIZE-1:0] w;
        for (int c = 0; c < NUM_COL; c++) w[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(row * 16 + c);
        return w;
    endfunction

    function automatic logic [WORDSIZE-1:0] random_word();
        logic [WORDSIZE-1:0] w;
        for (int i = 0; i < WORDSIZE / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // mode 0: mem_ready always high; 1: mem_ready low in cycles 2..9;
    // 2: random mem_ready and random psum_valid gaps with random data.
    task automatic run_job(input logic [ADDR_W-1:0] base, input int n, input int mode);
        logic [WORDSIZE-1:0] q[$];
        logic [WORDSIZE-1:0] w;
        logic [ADDR_W-1:0]   exp_addr;
        int  k = 0;
        int  wr = 0;
        bit  done_due;
        bit  done_seen = 0;
        bit  ready_exp, next_due;
        @(negedge clk);
        start = 1'b1; base_addr = base; num_rows = ROW_W'(n);
        psum_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_due = (n == 0);
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            if (done_seen) begin
                check("busy_after_done", busy, 0);
                check("done_one_cycle", done, 0);
                check("write_count", wr, n);
                return;
            end
            ready_exp = (k < n) && (q.size() < DEPTH);
            next_due  = (n > 0) && (k == n) && (q.size() == 0) && !done_due;
            check("done", done, done_due);
            check("busy", busy, 1);
            check("err", err, 0);
            check("psum_ready", psum_ready, ready_exp);
            check("mem_wr_en", mem_wr_en, q.size() > 0);
            if (q.size() > 0) begin
                exp_addr = base + ADDR_W'(wr);
                check("mem_addr", mem_addr, exp_addr);
                check("mem_wdata", mem_wdata, q[0]);
            end
            if (done_due) done_seen = 1;
            case (mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = !(cyc >= 2 && cyc <= 9);
                default: mem_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (mem_ready && q.size() > 0) begin
                void'(q.pop_front());
                wr++;
            end
            psum_valid = 1'b0;
            psum_data  = random_word();
            if (ready_exp && (mode != 2 || $urandom_range(0, 3) != 0)) begin
                w = (mode == 2) ? random_word() : pattern_word(k);
                psum_valid = 1'b1;
                psum_data  = w;
                q.push_back(reverse_cols(w));
                k++;
            end
            done_due = next_due;
            @(negedge clk);
        end
        check("job_timeout", done_seen, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_psum_ready"}, psum_ready, 0);
        check({tag, "_mem_wr_en"}, mem_wr_en, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic err_test();
        bit taken = 0;
        bit finished = 0;
        @(negedge clk);
        start = 1'b1; base_addr = 8'h40; num_rows = 8'd5;
        psum_valid = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check("err_fill_ready", psum_ready, 1);
            psum_valid = 1'b1; psum_data = pattern_word(i);
            @(negedge clk);
        end
        check("err_full_ready", psum_ready, 0);
        check("err_before", err, 0);
        psum_valid = 1'b1; psum_data = pattern_word(DEPTH);
        @(negedge clk);
        check("err_set", err, 1);
        repeat (3) @(negedge clk);
        check("err_sticky", err, 1);
        check("err_busy", busy, 1);
        mem_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
            if (taken) psum_valid = 1'b0;
            if (psum_ready && psum_valid) taken = 1;
            if (done) finished = 1;
            @(negedge clk);
        end
        check("err_job_done", finished, 1);
        check("err_hold_idle", err, 1);
    endtask

    task automatic reset_test();
        @(negedge clk);
        start = 1'b1; base_addr = 8'h20; num_rows = 8'd5;
        psum_valid = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            psum_valid = 1'b1; psum_data = pattern_word(i);
            @(negedge clk);
        end
        psum_valid = 1'b0;
        check("midjob_wr_en", mem_wr_en, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        repeat (3) begin
            @(negedge clk);
            check("rst_no_done", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_rst");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0;
        psum_valid = 1'b0; psum_data = '0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        run_job(8'h10, 3, 0);      // basic drain
        run_job(8'h50, 8, 1);      // back-pressure
        run_job(8'h00, 0, 0);      // zero rows
        run_job(8'hFE, 4, 0);      // address wrap
        err_test();
        run_job(8'h77, 0, 0);      // start clears err
        reset_test();
        run_job(8'h33, 5, 2);      // drains normally after reset
        for (int i = 0; i < 6; i++)
            run_job(ADDR_W'($urandom), $urandom_range(1, 20), 2);
        run_job(8'hC0, 255, 0);    // maximum row count

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
